decoder_scan: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with two modes: direct decode of a sampled select value, and autonomous scan that walks the one-hot output through every index with a programmable dwell time. It generalises the fixed combinational 4-to-16 decoders in the design into a clocked block. Intended uses are digit and row strobing for 7-segment displays, LED matrices and keypad scanning.

---
 rtl/decoder_pkg.sv | 13 +
 rtl/dec_onehot.sv | 14 +
 rtl/decoder_scan.sv | 113 +++++++++++
 tb/tb_decoder_scan.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the registered one-hot decoder: FSM states and mode encodings.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dec_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder; all zeros when en is low.
module dec_onehot #(
    parameter int SEL_W = 4
) (
    input  logic                    en,
    input  logic [SEL_W-1:0]        din,
    output logic [(2**SEL_W)-1:0]   dout
);

    localparam int N = 2**SEL_W;

    assign dout = en ? ({{(N-1){1'b0}}, 1'b1} << din) : '0;

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct and auto-scan modes; all outputs one cycle after inputs.
// Scan mode, dwell counter and wrap pulse exist only when DECODER_SCAN_EN is defined.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    mode,
    input  logic                    din_valid,
    input  logic [SEL_W-1:0]        din,
    input  logic [DWELL_W-1:0]      dwell,
    output logic [(2**SEL_W)-1:0]   dout,
    output logic                    dout_valid,
    output logic [SEL_W-1:0]        sel,
    output logic                    wrap
);

    localparam int N = 2**SEL_W;

    state_t             state;
    logic               scan_req;
    logic               advance;
    logic [SEL_W-1:0]   idx;
    logic [N-1:0]       oh;

`ifdef DECODER_SCAN_EN
    localparam logic [SEL_W-1:0] SEL_LAST = '1;
    logic [DWELL_W-1:0] cnt;

    assign scan_req = (mode == MODE_SCAN);
    // >= rather than == so a dwell lowered below the running count still advances.
    assign advance  = (cnt >= dwell);

    always_ff @(posedge clk) begin
        if (rst || !en || state != SCAN || !scan_req) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (advance) begin
            cnt  <= '0;
            wrap <= (sel == SEL_LAST);
        end else begin
            cnt  <= cnt + 1'b1;
            wrap <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{mode, dwell};
    assign scan_req   = 1'b0;
    assign advance    = 1'b0;
    assign wrap       = 1'b0;
`endif

    // Single decoder: scan entry decodes 0, running scan decodes sel+1, otherwise din.
    always_comb begin
        idx = din;
        if (scan_req) begin
            idx = (state == SCAN) ? sel + 1'b1 : '0;
        end
    end

    dec_onehot #(.SEL_W(SEL_W)) u_dec (
        .en   (en),
        .din  (idx),
        .dout (oh)
    );

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            sel        <= '0;
        end else begin
            case (state)
                IDLE, DIRECT: begin
                    if (scan_req) begin
                        state      <= SCAN;
                        sel        <= '0;
                        dout       <= oh;
                        dout_valid <= 1'b1;
                    end else begin
                        state <= DIRECT;
                        if (state == DIRECT && din_valid) begin
                            sel        <= din;
                            dout       <= oh;
                            dout_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!scan_req) begin
                        state      <= DIRECT;
                        dout       <= '0;
                        dout_valid <= 1'b0;
                        sel        <= '0;
                    end else if (advance) begin
                        sel  <= idx;
                        dout <= oh;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan; scan scenarios run only when DECODER_SCAN_EN is defined.
module tb_decoder_scan;

    logic        clk = 1'b0;
    logic        rst, en, mode, din_valid;
    logic [3:0]  din;
    logic [15:0] dwell;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  sel;
    logic        wrap;

    typedef struct packed {
        logic [15:0] dout;
        logic        vld;
        logic [3:0]  sel;
        logic        wrap;
    } obs_t;

    obs_t got, e;
    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    assign got = {dout, dout_valid, sel, wrap};

    decoder_scan #(.SEL_W(4), .DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .din_valid  (din_valid),
        .din        (din),
        .dwell      (dwell),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sel        (sel),
        .wrap       (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t mk(int idx, logic v, logic w);
        mk = {(v ? 16'(1 << idx) : 16'h0000), v, 4'(idx), w};
    endfunction

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; din_valid = 1'b0; din = '0; dwell = '0;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(0, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset cyc%0d got=%h want=%h", i, got, e);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_direct();
        en = 1'b1; mode = 1'b0;
        sb.push_back(mk(0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL direct_entry got=%h want=%h", got, e);
        end
        din = 4'd9; din_valid = 1'b1;
        sb.push_back({16'h0200, 1'b1, 4'd9, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) begin
            din_valid = 1'b0; din = 4'd3;
            sb.push_back({16'h0200, 1'b1, 4'd9, 1'b0});
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL direct_9_hold cyc%0d got=%h want=%h", i, got, e);
            end
            tick();
        end
        void'(sb.pop_front());
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            din = 4'(i); din_valid = 1'b1;
            sb.push_back(mk(i, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e || $countones(dout) != 1) begin
                bad++;
                $display("FAIL sweep din=%0d got=%h want=%h", i, got, e);
            end
        end
        din_valid = 1'b0;
    endtask

`ifdef DECODER_SCAN_EN
    task automatic test_scan_dwell();
        mode = 1'b1; dwell = 16'd2;
        for (int k = 0; k <= 96; k++) begin
            sb.push_back(mk((k / 3) % 16, 1'b1, (k > 0 && k % 48 == 0)));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scan_dwell2 k=%0d got=%h want=%h", k, got, e);
            end
        end
    endtask

    task automatic test_dwell0_and_change();
        en = 1'b0;
        sb.push_back(mk(0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL disable got=%h want=%h", got, e);
        end
        en = 1'b1; mode = 1'b1; dwell = 16'd0;
        for (int k = 0; k <= 33; k++) begin
            sb.push_back(mk(k % 16, 1'b1, (k > 0 && k % 16 == 0)));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scan_dwell0 k=%0d got=%h want=%h", k, got, e);
            end
        end
        en = 1'b0;
        tick();
        en = 1'b1; dwell = 16'd10;
        for (int k = 0; k <= 5; k++) begin
            sb.push_back(mk(0, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL dwell10_count k=%0d got=%h want=%h", k, got, e);
            end
        end
        dwell = 16'd1;
        for (int m = 1; m <= 8; m++) begin
            sb.push_back(mk(1 + (m - 1) / 2, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL dwell_change m=%0d got=%h want=%h", m, got, e);
            end
        end
    endtask

    task automatic test_mode_switch();
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; dwell = 16'd0; din_valid = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            sb.push_back(mk(k, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL to_sel7 k=%0d got=%h want=%h", k, got, e);
            end
        end
        mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(0, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got.dout !== e.dout || got.vld !== e.vld || got.wrap !== e.wrap) begin
                bad++;
                $display("FAIL scan_to_direct k=%0d got=%h want=%h", k, got, e);
            end
        end
        din = 4'd5; din_valid = 1'b1;
        sb.push_back(mk(5, 1'b1, 1'b0));
        tick();
        din_valid = 1'b0; mode = 1'b1;
        sb.push_back(mk(0, 1'b1, 1'b0));
        tick();
        en = 1'b0;
        sb.push_back(mk(0, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            total++;
            if (k == 0 && got !== sb[0]) begin
                bad++;
                $display("FAIL direct_then_rescan got=%h want=%h", got, sb[0]);
            end
            tick();
        end
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL en_drop got=%h want=%h", got, e);
        end
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b1; mode = 1'b1; dwell = 16'd0;
        for (int k = 0; k <= 12; k++) begin
            sb.push_back(mk(k, 1'b1, 1'b0));
            tick();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL to_sel12 k=%0d got=%h want=%h", k, got, e);
            end
        end
        rst = 1'b1;
        sb.push_back(mk(0, 1'b0, 1'b0));
        tick();
        rst = 1'b0;
        sb.push_back(mk(0, 1'b1, 1'b0));
        sb.push_back(mk(1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++) begin
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rst_mid_scan step%0d got=%h want=%h", k, got, e);
            end
            if (k < 2) tick();
        end
    endtask
`else
    task automatic test_macro_off();
        en = 1'b0;
        tick();
        en = 1'b1; mode = 1'b1; dwell = 16'd0; din_valid = 1'b0;
        sb.push_back(mk(0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL off_entry got=%h want=%h", got, e);
        end
        din = 4'd6; din_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sb.push_back(mk(6, 1'b1, 1'b0));
            tick();
            din_valid = 1'b0; din = 4'd2;
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL off_decode k=%0d got=%h want=%h", k, got, e);
            end
        end
        en = 1'b0;
        sb.push_back(mk(0, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL off_en_drop got=%h want=%h", got, e);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_direct();
        test_sweep();
`ifdef DECODER_SCAN_EN
        test_scan_dwell();
        test_dwell0_and_change();
        test_mode_switch();
        test_reset_mid_scan();
`else
        test_macro_off();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
